// File: rtl/seven_seg_pkg.sv
// Shared constants, state encoding and anode decode for the 4-digit scan controller.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Active-low one-cold enable for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] digit_anode(input logic [SEL_W-1:0] sel);
    return ~(NUM_DIGITS'(1) << sel);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Dwell counter shared by the ON and GAP phases: restarts at zero, counts up and
// parks at the terminal count until restarted.
module scan_timer #(
  parameter int W = 3
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         restart,
  input  logic [W-1:0] limit,
  output logic         terminal
);

  logic [W-1:0] count;

  assign terminal = (count == limit);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (!terminal) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Blanking-gap scan controller with frame-synchronous double-buffered display word.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading-zero digits 3..1).
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic                            Clock,
  input  logic                            nReset,
  input  logic                            Enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   DataIn,
  input  logic                            Update,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   DisplayData,
  output logic [SEL_W-1:0]                Selector,
  output logic [NUM_DIGITS-1:0]           Anode,
  output logic                            FrameStart,
  output logic                            UpdateAck
);

  localparam int MAX_CYC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DIGIT_LIM = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_DIGITS - 1);

  scan_state_t state, state_nx;
  logic [SEL_W-1:0]              sel_nx;
  logic [NUM_DIGITS*DIGIT_W-1:0] data_nx, pend_data, pend_data_nx;
  logic                          pending, pend_nx;
  logic                          frame_nx, ack_nx, commit, restart, terminal;
  logic [CNT_W-1:0]              limit;
  logic [NUM_DIGITS-1:0]         anode_nx, blank;

  assign limit = (state == GAP) ? GAP_LIM : DIGIT_LIM;

  scan_timer #(.W(CNT_W)) u_timer (
    .Clock    (Clock),
    .nReset   (nReset),
    .restart  (restart),
    .limit    (limit),
    .terminal (terminal)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = {data_nx[15:12] == 4'h0, data_nx[15:8] == 8'h0,
                  data_nx[15:4] == 12'h0, 1'b0};
`else
  assign blank = '0;
`endif

  // Next-state, selector, commit buffer and registered anode decode.
  always_comb begin
    state_nx     = state;
    sel_nx       = Selector;
    data_nx      = DisplayData;
    pend_data_nx = pend_data;
    pend_nx      = pending;
    frame_nx     = 1'b0;
    ack_nx       = 1'b0;
    commit       = 1'b0;
    restart      = 1'b0;

    case (state)
      IDLE: begin
        restart = 1'b1;
        if (Enable) begin
          state_nx = ON;
          sel_nx   = '0;
          frame_nx = 1'b1;
          commit   = 1'b1;
        end
      end
      ON: begin
        if (!Enable) begin
          state_nx = IDLE;
          sel_nx   = '0;
          restart  = 1'b1;
        end else if (terminal) begin
          restart = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_nx = GAP;
          end else begin
            sel_nx   = Selector + SEL_W'(1);
            frame_nx = (Selector == LAST_SEL);
            commit   = (Selector == LAST_SEL);
          end
        end
      end
      GAP: begin
        if (!Enable) begin
          state_nx = IDLE;
          sel_nx   = '0;
          restart  = 1'b1;
        end else if (terminal) begin
          restart  = 1'b1;
          state_nx = ON;
          sel_nx   = Selector + SEL_W'(1);
          frame_nx = (Selector == LAST_SEL);
          commit   = (Selector == LAST_SEL);
        end
      end
      default: begin
        state_nx = IDLE;
        sel_nx   = '0;
        restart  = 1'b1;
      end
    endcase

    // A fresh Update on a commit cycle (or while idle) bypasses the pending buffer.
    if (Update && (commit || state == IDLE)) begin
      data_nx = DataIn;
      pend_nx = 1'b0;
      ack_nx  = 1'b1;
    end else if (commit && pending) begin
      data_nx = pend_data;
      pend_nx = 1'b0;
      ack_nx  = 1'b1;
    end else if (Update) begin
      pend_data_nx = DataIn;
      pend_nx      = 1'b1;
    end

    anode_nx = (state_nx == ON) ? (digit_anode(sel_nx) | blank) : ANODE_OFF;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      Selector    <= '0;
      Anode       <= ANODE_OFF;
      DisplayData <= '0;
      pend_data   <= '0;
      pending     <= 1'b0;
      FrameStart  <= 1'b0;
      UpdateAck   <= 1'b0;
    end else begin
      state       <= state_nx;
      Selector    <= sel_nx;
      Anode       <= anode_nx;
      DisplayData <= data_nx;
      pend_data   <= pend_data_nx;
      pending     <= pend_nx;
      FrameStart  <= frame_nx;
      UpdateAck   <= ack_nx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with DIGIT_CYCLES=4, GAP_CYCLES=2 (24-cycle frame).
module tb_seven_seg_scan_ctrl;

  localparam int DIG   = 4;
  localparam int GAP   = 2;
  localparam int SLOT  = DIG + GAP;
  localparam int FRAME = 4 * SLOT;

  logic        Clock = 1'b0;
  logic        nReset, Enable, Update, FrameStart, UpdateAck;
  logic [15:0] DataIn, DisplayData;
  logic [1:0]  Selector;
  logic [3:0]  Anode;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] sb[$];
  bit          m_on, m_pend;
  int          m_k;
  logic [15:0] m_disp;

  seven_seg_scan_ctrl #(.DIGIT_CYCLES(DIG), .GAP_CYCLES(GAP)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Enable      (Enable),
    .DataIn      (DataIn),
    .Update      (Update),
    .DisplayData (DisplayData),
    .Selector    (Selector),
    .Anode       (Anode),
    .FrameStart  (FrameStart),
    .UpdateAck   (UpdateAck)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] modelAnode();
    int pos;
    logic [3:0] a;
    if (!m_on) return 4'hF;
    pos = m_k % FRAME;
    if ((pos % SLOT) >= DIG) return 4'hF;
    a = 4'hF;
    a[pos / SLOT] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int n = 1; n < 4; n++)
      if ((m_disp >> (4 * n)) == 16'h0) a[n] = 1'b1;
`endif
    return a;
  endfunction

  // One clock of stimulus; expected commits go on the scoreboard as Updates are driven.
  task automatic applyStimulus(input bit en, input bit upd, input logic [15:0] din);
    bit          wasOn, commitEdge, expAck;
    logic [1:0]  prevSel;
    logic [3:0]  prevAnode;
    int          pos;
    wasOn     = m_on;
    prevSel   = Selector;
    prevAnode = Anode;
    Enable    = en;
    Update    = upd;
    DataIn    = din;
    if (en) begin
      if (!m_on) begin
        m_on = 1'b1;
        m_k  = 0;
      end else begin
        m_k++;
      end
    end else begin
      m_on = 1'b0;
      m_k  = 0;
    end
    commitEdge = en && (m_k % FRAME == 0);
    if (upd) begin
      if (m_pend) void'(sb.pop_back());
      sb.push_back(din);
      m_pend = 1'b1;
    end
    expAck = m_pend && (commitEdge || (!wasOn && upd));
    if (expAck) m_pend = 1'b0;

    @(negedge Clock);
    pos = m_k % FRAME;
    if (UpdateAck && sb.size() > 0) m_disp = sb.pop_front();
    checkOutput("ack", {15'b0, UpdateAck}, {15'b0, expAck});
    checkOutput("display", DisplayData, m_disp);
    checkOutput("anode", {12'b0, Anode}, {12'b0, modelAnode()});
    checkOutput("selector", {14'b0, Selector}, m_on ? 16'(pos / SLOT) : 16'h0);
    checkOutput("frameStart", {15'b0, FrameStart}, {15'b0, (m_on && pos == 0)});
    if (wasOn && m_on && Selector !== prevSel)
      checkOutput("selInGap", {12'b0, prevAnode}, 16'h000F);
  endtask

  // Idle-scan until the next clock edge lands on frame position p.
  task automatic runUntil(input int p);
    for (int i = 0; i < 3 * FRAME && ((m_k + 1) % FRAME) != p; i++)
      applyStimulus(1'b1, 1'b0, 16'h0);
    if (((m_k + 1) % FRAME) != p)
      checkOutput("runUntil", 16'((m_k + 1) % FRAME), 16'(p));
  endtask

  initial begin
    nReset = 1'b0;
    Enable = 1'b0;
    Update = 1'b0;
    DataIn = 16'h0;
    m_on   = 1'b0;
    m_pend = 1'b0;
    m_k    = 0;
    m_disp = 16'h0;

    repeat (2) @(negedge Clock);
    checkOutput("rstAnode", {12'b0, Anode}, 16'h000F);
    checkOutput("rstSel", {14'b0, Selector}, 16'h0);
    checkOutput("rstData", DisplayData, 16'h0);
    checkOutput("rstFrame", {15'b0, FrameStart}, 16'h0);
    checkOutput("rstAck", {15'b0, UpdateAck}, 16'h0);
    nReset = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 16'h0);

    // Plain scanning over two frames.
    repeat (2 * FRAME) applyStimulus(1'b1, 1'b0, 16'h0);

    // Update during digit 2 is held until the wrap.
    runUntil(13);
    applyStimulus(1'b1, 1'b1, 16'h1234);
    runUntil(0);
    applyStimulus(1'b1, 1'b0, 16'h0);

    // Last Update in a frame wins; an Update on the commit cycle goes straight through.
    runUntil(3);
    applyStimulus(1'b1, 1'b1, 16'h1111);
    runUntil(10);
    applyStimulus(1'b1, 1'b1, 16'h2222);
    runUntil(0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    runUntil(8);
    applyStimulus(1'b1, 1'b1, 16'hAAAA);
    runUntil(0);
    applyStimulus(1'b1, 1'b1, 16'h5678);
    runUntil(0);
    applyStimulus(1'b1, 1'b1, 16'h9ABC);

    // Leading-zero patterns across full frames.
    runUntil(20);
    applyStimulus(1'b1, 1'b1, 16'h0040);
    runUntil(0);
    repeat (FRAME) applyStimulus(1'b1, 1'b0, 16'h0);
    runUntil(20);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    runUntil(0);
    repeat (FRAME) applyStimulus(1'b1, 1'b0, 16'h0);

    // Disable in digit 2, idle Update, restart, and pending commit on re-enable.
    runUntil(14);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h4321);
    applyStimulus(1'b0, 1'b0, 16'h0);
    repeat (8) applyStimulus(1'b1, 1'b0, 16'h0);
    runUntil(5);
    applyStimulus(1'b1, 1'b1, 16'h0F0F);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);

    // Asynchronous reset in the middle of a gap.
    runUntil(10);
    applyStimulus(1'b1, 1'b0, 16'h0);
    #2;
    nReset = 1'b0;
    Enable = 1'b0;
    #1;
    checkOutput("asyncAnode", {12'b0, Anode}, 16'h000F);
    checkOutput("asyncSel", {14'b0, Selector}, 16'h0);
    checkOutput("asyncData", DisplayData, 16'h0);
    sb.delete();
    m_on   = 1'b0;
    m_pend = 1'b0;
    m_k    = 0;
    m_disp = 16'h0;
    @(negedge Clock);
    nReset = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0);
    repeat (FRAME) applyStimulus(1'b1, 1'b0, 16'h0);

    checkOutput("sbEmpty", 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
